// File: rtl/mwadd_pkg.sv
// Shared types for the sequential multi-word adder: word width and control states.
package mwadd_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/adder_32bit.sv
// 32-bit carry-lookahead adder, no carry-in: 4-bit groups with lookahead between groups.
// Purely combinational; S is the 32-bit sum, C32 the carry out of bit 31.
module adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] s,
  output logic        c32
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;
  logic [7:0]  gg;
  logic [7:0]  gp;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    gg = '0;
    gp = '0;
    c  = '0;
    for (int k = 0; k < 8; k++) begin
      gp[k] = &p[4*k +: 4];
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
    // group carries first, then the in-group carries derived from each group's carry-in
    for (int k = 0; k < 8; k++) begin
      c[4*k+4] = gg[k] | (gp[k] & c[4*k]);
    end
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 3; i++) begin
        c[4*k+i+1] = g[4*k+i] | (p[4*k+i] & c[4*k+i]);
      end
    end
  end

  assign s   = p ^ c[31:0];
  assign c32 = c[32];

endmodule

// File: rtl/multiword_add_seq.sv
// Sequential WORDS x 32-bit adder around one adder_32bit, LSW first, one word per clock; MWADD_SUB_EN adds A-B.
// Latency: result valid WORDS cycles after acceptance; one operation per WORDS+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module multiword_add_seq
  import mwadd_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_W*WORDS-1:0] in_a,
  input  logic [WORD_W*WORDS-1:0] in_b,
`ifdef MWADD_SUB_EN
  input  logic                    in_sub,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_W*WORDS-1:0] out_sum,
  output logic                    out_carry
);

  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_e            state;
  state_e            state_nxt;
  logic [IDX_W-1:0]  idx;
  logic              c;
  logic              carry_q;
  logic [WORD_W-1:0] a_q   [WORDS];
  logic [WORD_W-1:0] b_q   [WORDS];
  logic [WORD_W-1:0] sum_q [WORDS];
  logic [WORD_W-1:0] s_w;
  logic              c32_w;
  logic [WORD_W-1:0] word_res;
  logic              c_nxt;
  logic              accept;
  logic              sub_req;

`ifdef MWADD_SUB_EN
  assign sub_req = in_sub;
`else
  assign sub_req = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (idx == LAST_IDX) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  adder_32bit u_adder (
    .a   (a_q[idx]),
    .b   (b_q[idx]),
    .s   (s_w),
    .c32 (c32_w)
  );

  // C32 and an all-ones S never coincide, so the incoming carry only ripples through all-ones
  assign word_res = s_w + {{(WORD_W-1){1'b0}}, c};
  assign c_nxt    = c32_w | (c & (&s_w));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      c       <= 1'b0;
      carry_q <= 1'b0;
      for (int w = 0; w < WORDS; w++) begin
        a_q[w]   <= '0;
        b_q[w]   <= '0;
        sum_q[w] <= '0;
      end
    end else if (accept) begin
      idx <= '0;
      c   <= sub_req;
      for (int w = 0; w < WORDS; w++) begin
        a_q[w] <= in_a[w*WORD_W +: WORD_W];
        b_q[w] <= in_b[w*WORD_W +: WORD_W] ^ {WORD_W{sub_req}};
      end
    end else if (state == RUN) begin
      sum_q[idx] <= word_res;
      c          <= c_nxt;
      if (idx == LAST_IDX) begin
        carry_q <= c_nxt;
        idx     <= '0;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  always_comb begin
    out_sum = '0;
    for (int w = 0; w < WORDS; w++) begin
      out_sum[w*WORD_W +: WORD_W] = sum_q[w];
    end
  end

  assign out_carry = carry_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Randomized and directed bench for multiword_add_seq against a wide-integer reference model.
module tb_multiword_add_seq;

  localparam int WORDS = 4;
  localparam int W     = 32 * WORDS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
`ifdef MWADD_SUB_EN
  logic         in_sub = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_carry;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;

  multiword_add_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
`ifdef MWADD_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain (W+1)-bit arithmetic; subtraction as A + ~B + 1 so the top bit is "no borrow".
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic [W-1:0] nb;
    nb = ~b;
    if (sub) return {1'b0, a} + {1'b0, nb} + (W+1)'(1);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic [31:0] rword();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0;
      default: return 32'($urandom);
    endcase
  endfunction

  function automatic logic [W-1:0] rop();
    logic [W-1:0] v;
    for (int i = 0; i < WORDS; i++) v[32*i +: 32] = rword();
    return v;
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        output logic [W-1:0] s, output logic co);
    int n;
    logic [W:0] exp;
    exp = ref_add(a, b, sub);
    out_ready = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 64) begin tick(); n++; end
    chk("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
`ifdef MWADD_SUB_EN
    in_sub = sub;
`endif
    tick();
    acc_cyc = cyc;
    in_valid = 1'b0;
    in_a = rop();
    in_b = rop();
    chk("in_ready_low_in_run", in_ready, 0);
    n = 0;
    while (out_valid !== 1'b1 && n < 64) begin tick(); n++; end
    chk("latency", n, WORDS);
    s  = out_sum;
    co = out_carry;
    chk("sum", out_sum, exp[W-1:0]);
    chk("carry", out_carry, exp[W]);
    tick();
    chk("out_valid_after_handshake", out_valid, 0);
    chk("in_ready_after_handshake", in_ready, 1);
  endtask

  initial begin
    logic [W-1:0] a, b, a2, b2, s;
    logic [W:0]   exp;
    logic         co;
    int           n;
    int           prev;

    // reset state
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_carry", out_carry, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", in_ready, 1);

    // reset in the middle of RUN after two words
    in_valid = 1'b1;
    in_a = rop();
    in_b = rop();
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("midrun_rst_out_valid", out_valid, 0);
    chk("midrun_rst_out_sum", out_sum, 0);
    chk("midrun_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    tick();
    run_op(W'(1), W'(1), 1'b0, s, co);
    chk("one_plus_one_sum", s, 2);
    chk("one_plus_one_carry", co, 0);

    // full carry ripple through every word
    a = '1;
    run_op(a, W'(1), 1'b0, s, co);
    chk("allones_sum", s, 0);
    chk("allones_carry", co, 1);

    // incoming carry meets an all-ones partial sum
    a = 128'h0000_0000_0000_0000_FFFF_FFFE_FFFF_FFFF;
    b = 128'h0000_0000_0000_0000_0000_0001_0000_0001;
    run_op(a, b, 1'b0, s, co);
    chk("carry_into_ones_sum", s, 128'h0000_0000_0000_0001_0000_0000_0000_0000);
    chk("carry_into_ones_carry", co, 0);

    // backpressure in DONE with a competing request upstream
    a = rop();
    b = rop();
    exp = ref_add(a, b, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
`ifdef MWADD_SUB_EN
    in_sub = 1'b0;
`endif
    tick();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 64) begin tick(); n++; end
    chk("bp_latency", n, WORDS);
    a2 = rop();
    b2 = rop();
    in_valid = 1'b1;
    in_a = a2;
    in_b = b2;
    for (int i = 0; i < 3; i++) begin
      chk("bp_sum_stable", out_sum, exp[W-1:0]);
      chk("bp_carry_stable", out_carry, exp[W]);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      tick();
    end
    chk("bp_sum_stable_last", out_sum, exp[W-1:0]);
    out_ready = 1'b1;
    tick();
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_no_accept_in_done", in_ready, 1);
    in_valid = 1'b0;
    run_op(a2, b2, 1'b0, s, co);

`ifdef MWADD_SUB_EN
    run_op(W'(5), W'(7), 1'b1, s, co);
    chk("sub_5_7_sum", s, {{(W-1){1'b1}}, 1'b0});
    chk("sub_5_7_carry", co, 0);
    run_op(W'(7), W'(5), 1'b1, s, co);
    chk("sub_7_5_sum", s, 2);
    chk("sub_7_5_carry", co, 1);
`endif

    // back-to-back random traffic with out_ready held high
    prev = 0;
    for (int i = 0; i < 1000; i++) begin
      logic sub;
`ifdef MWADD_SUB_EN
      sub = 1'($urandom_range(0, 1));
`else
      sub = 1'b0;
`endif
      run_op(rop(), rop(), sub, s, co);
      if (i > 0) chk("throughput", acc_cyc - prev, WORDS + 2);
      prev = acc_cyc;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
